// File: rtl/message_schedule_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message schedule block.
//   - schedState_t : FSM state encoding (IDLE, RUN, DONE)
//   - WORD_W, SCHED_LEN, WINDOW_LEN, BLOCK_W, T_W : fixed datapath geometry
//   - S0_* / S1_* : rotate and shift amounts of the small sigma functions
//   - rotr()      : 32-bit circular right rotate helper
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SCHED_LEN  = 64;
  localparam int unsigned WINDOW_LEN = 16;
  localparam int unsigned BLOCK_W    = WORD_W * WINDOW_LEN;
  localparam int unsigned T_W        = $clog2(SCHED_LEN);

  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

  localparam logic [T_W-1:0] LAST_T = T_W'(SCHED_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } schedState_t;

  // Circular right rotate; amount must lie in 1..WORD_W-1.
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned amount);
    return (x >> amount) | (x << (WORD_W - amount));
  endfunction

endpackage

// File: rtl/message_schedule_if.sv
// ---------------------------------------------------------------------------
// message_schedule_if
// Bundles the block-load request and the word stream of message_schedule.
//   start   : request to load blockIn (producer -> schedule)
//   blockIn : 512-bit message block, W[0] in the top word
//   wOut    : current schedule word W[t]
//   tOut    : index t of wOut
//   wValid  : wOut/tOut valid
//   wReady  : consumer accepts wOut this cycle
//   busy    : schedule is streaming words
//   done    : one-cycle pulse after the last word is accepted
// Modports: master = environment driving start/blockIn/wReady,
//           slave  = the schedule block itself.
// ---------------------------------------------------------------------------
interface message_schedule_if;
  import sha256_pkg::*;

  logic                start;
  logic [BLOCK_W-1:0]  blockIn;
  logic [WORD_W-1:0]   wOut;
  logic [T_W-1:0]      tOut;
  logic                wValid;
  logic                wReady;
  logic                busy;
  logic                done;

  modport master (
    output start, blockIn, wReady,
    input  wOut, tOut, wValid, busy, done
  );

  modport slave (
    input  start, blockIn, wReady,
    output wOut, tOut, wValid, busy, done
  );

endinterface

// File: rtl/message_schedule_sigma.sv
// ---------------------------------------------------------------------------
// sha256_small_sigma
// Purely combinational SHA-256 small sigma functions of one word.
//   x  : input word
//   s0 : ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
//   s1 : ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
// ---------------------------------------------------------------------------
module sha256_small_sigma
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  assign s0 = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  assign s1 = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);

endmodule

// File: rtl/message_schedule.sv
// ---------------------------------------------------------------------------
// message_schedule
// Expands a 512-bit block into the 64-word SHA-256 message schedule and
// streams it out one word per accepted transfer.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : message_schedule_if.slave (start/blockIn in, word stream out)
// A 16-word sliding window holds W[t..t+15]; window[0] is the word on offer.
// ---------------------------------------------------------------------------
module message_schedule
  import sha256_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  message_schedule_if.slave bus
);

  schedState_t        state;
  schedState_t        stateNext;
  logic [WORD_W-1:0]  window [WINDOW_LEN];
  logic [T_W-1:0]     t;
  logic [WORD_W-1:0]  sigma0Lo;
  logic [WORD_W-1:0]  sigma1Hi;
  logic [WORD_W-1:0]  unusedS1Lo;
  logic [WORD_W-1:0]  unusedS0Hi;
  logic [WORD_W-1:0]  newWord;
  logic               loadBlock;
  logic               transfer;
  logic               shiftWindow;

  // window[1] is W[t+1] and window[14] is W[t+14]; only one sigma of each
  // instance is needed for the recurrence.
  sha256_small_sigma sigmaLo (
    .x  (window[1]),
    .s0 (sigma0Lo),
    .s1 (unusedS1Lo)
  );

  sha256_small_sigma sigmaHi (
    .x  (window[14]),
    .s0 (unusedS0Hi),
    .s1 (sigma1Hi)
  );

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], carries discarded.
  assign newWord = sigma1Hi + window[9] + sigma0Lo + window[0];

  assign loadBlock   = (state == IDLE) && bus.start;
  assign transfer    = (state == RUN) && bus.wReady;
  // The final transfer leaves the window and t untouched so W[63] stays on wOut.
  assign shiftWindow = transfer && (t != LAST_T);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.start) stateNext = RUN;
      RUN:     if (transfer && (t == LAST_T)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    bus.wValid = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      RUN: begin
        bus.wValid = 1'b1;
        bus.busy   = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Window and index: load on an accepted start, slide on each transfer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WINDOW_LEN; i++) window[i] <= '0;
      t <= '0;
    end else if (loadBlock) begin
      for (int i = 0; i < WINDOW_LEN; i++)
        window[i] <= bus.blockIn[(WINDOW_LEN - 1 - i) * WORD_W +: WORD_W];
      t <= '0;
    end else if (shiftWindow) begin
      for (int i = 0; i < WINDOW_LEN - 1; i++) window[i] <= window[i + 1];
      window[WINDOW_LEN - 1] <= newWord;
      t <= t + 1'b1;
    end
  end

  assign bus.wOut = window[0];
  assign bus.tOut = t;

endmodule

// File: tb/tb_message_schedule.sv
// ---------------------------------------------------------------------------
// tb_message_schedule
// Self-checking bench for message_schedule: the full 64-word schedule of each
// block is computed directly from the SHA-256 recurrence and every streamed
// word, index and status flag is compared against it.
// ---------------------------------------------------------------------------
module tb_message_schedule;
  import sha256_pkg::*;

  logic clock = 1'b0;
  logic resetn;

  message_schedule_if bus ();

  message_schedule dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] refW [64];
  logic [31:0] gotW [64];

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drives the block-load request inputs.
  task automatic applyStimulus(input logic startVal, input logic [511:0] blk);
    bus.start   = startVal;
    bus.blockIn = blk;
  endtask

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference schedule straight from the SHA-256 definition.
  function automatic void buildRef(input logic [511:0] blk);
    logic [31:0] s0;
    logic [31:0] s1;
    for (int i = 0; i < 16; i++) refW[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr32(refW[i-15], 7) ^ rotr32(refW[i-15], 18) ^ (refW[i-15] >> 3);
      s1 = rotr32(refW[i-2], 17) ^ rotr32(refW[i-2], 19) ^ (refW[i-2] >> 10);
      refW[i] = s1 + refW[i-7] + s0 + refW[i-16];
    end
  endfunction

  function automatic logic [511:0] randomBlock();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i * 32 +: 32] = $urandom();
    return b;
  endfunction

  // Loads blk from IDLE, consumes all 64 words with the given ready
  // probability, then checks the DONE pulse and the following IDLE cycle.
  task automatic consumeStream(input logic [511:0] blk, input int readyPct,
                               input bit injectStart, input bit holdStart,
                               output int cyclesUsed);
    int          idx;
    bit          prevStall;
    bit          injected;
    logic [31:0] prevWord;
    logic [5:0]  prevT;
    buildRef(blk);
    applyStimulus(1'b1, blk);
    @(negedge clock);
    idx = 0;
    cyclesUsed = 0;
    prevStall = 1'b0;
    injected = 1'b0;
    prevWord = '0;
    prevT = '0;
    while (idx < 64 && cyclesUsed < 2000) begin
      checkOutput("runValid", bus.wValid, 1);
      checkOutput("runBusy", bus.busy, 1);
      checkOutput("runDone", bus.done, 0);
      checkOutput("word", bus.wOut, refW[idx]);
      checkOutput("index", bus.tOut, idx);
      if (prevStall) begin
        checkOutput("stallWord", bus.wOut, prevWord);
        checkOutput("stallIndex", bus.tOut, prevT);
      end
      bus.wReady = ($urandom_range(0, 99) < readyPct);
      if (injectStart && idx == 10 && !injected) begin
        applyStimulus(1'b1, randomBlock());
        injected = 1'b1;
      end else begin
        applyStimulus(holdStart, blk);
      end
      prevStall = !bus.wReady;
      prevWord  = bus.wOut;
      prevT     = bus.tOut;
      if (bus.wReady) begin
        gotW[idx] = bus.wOut;
        idx++;
      end
      cyclesUsed++;
      @(negedge clock);
    end
    if (idx < 64) checkOutput("timeout", idx, 64);
    checkOutput("donePulse", bus.done, 1);
    checkOutput("doneValid", bus.wValid, 0);
    checkOutput("doneBusy", bus.busy, 0);
    applyStimulus(holdStart, blk);
    @(negedge clock);
    checkOutput("idleDone", bus.done, 0);
    checkOutput("idleValid", bus.wValid, 0);
    checkOutput("idleBusy", bus.busy, 0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          guard;
    logic [511:0] blk;

    resetn = 1'b1;
    bus.wReady = 1'b0;
    applyStimulus(1'b0, '0);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rstWOut", bus.wOut, 0);
    checkOutput("rstTOut", bus.tOut, 0);
    checkOutput("rstValid", bus.wValid, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    bus.wReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("noStartValid", bus.wValid, 0);
    end

    $display("[TB] abc block, ready always high");
    consumeStream(ABC_BLOCK, 100, 1'b0, 1'b0, cyc);
    checkOutput("b2bCycles", cyc, 64);
    checkOutput("abcW16", gotW[16], 32'h61626380);
    checkOutput("abcW17", gotW[17], 32'h000F0000);
    checkOutput("abcW18", gotW[18], 32'h7DA86405);
    checkOutput("abcW63", gotW[63], 32'h12B1EDEB);

    $display("[TB] all-zero block");
    consumeStream('0, 100, 1'b0, 1'b0, cyc);

    $display("[TB] abc block, random backpressure");
    consumeStream(ABC_BLOCK, 50, 1'b0, 1'b0, cyc);
    checkOutput("bpAbcW63", gotW[63], 32'h12B1EDEB);

    $display("[TB] start pulse at t=10 ignored");
    consumeStream(randomBlock(), 70, 1'b1, 1'b0, cyc);

    $display("[TB] reset during run at t=30");
    blk = randomBlock();
    applyStimulus(1'b1, blk);
    bus.wReady = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0, blk);
    guard = 0;
    while (bus.tOut != 6'd30 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("preRstIndex", bus.tOut, 30);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midRstWOut", bus.wOut, 0);
    checkOutput("midRstTOut", bus.tOut, 0);
    checkOutput("midRstValid", bus.wValid, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstDone", bus.done, 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("postRstValid", bus.wValid, 0);
    end
    consumeStream(randomBlock(), 80, 1'b0, 1'b0, cyc);

    $display("[TB] start held high across two runs");
    consumeStream(randomBlock(), 100, 1'b0, 1'b1, cyc);
    consumeStream(randomBlock(), 100, 1'b0, 1'b1, cyc);
    applyStimulus(1'b0, '0);
    @(negedge clock);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/message_schedule.md
MESSAGE_SCHEDULE -- requirements
Module: message_schedule

Interface
REQ-001 Parameters: none; word width is fixed at 32 bits and the schedule length is fixed at 64 words.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to load a new 512-bit block; sampled only in IDLE.
REQ-005 blockIn  input  512  message block; W[0]=blockIn[511:480], ..., W[15]=blockIn[31:0] (big-endian word order).
REQ-006 wOut  output  32  current schedule word W[t].
REQ-007 tOut  output  6  index t of wOut.
REQ-008 wValid  output  1  wOut/tOut are valid.
REQ-009 wReady  input  1  consumer accepts wOut this cycle.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  one-cycle pulse after W[63] is accepted.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 IDLE with start=1: latch W[0..15] into a 16-word window, set t=0, go to RUN; wOut=W[0] and wValid=1 on the next cycle (latency 1).
REQ-014 RUN: wValid=1, busy=1, wOut=window[0], tOut=t.
REQ-015 Transfer occurs on wValid&&wReady; with no transfer the window, t and outputs SHALL hold (stable under backpressure).
REQ-016 On transfer with t<63: shift the window down one word, append W[t+16]=s1(W[t+14])+W[t+9]+s0(W[t+1])+W[t] mod 2^32, increment t.
REQ-017 s0(x)=ROTR7(x)^ROTR18(x)^SHR3(x); s1(x)=ROTR17(x)^ROTR19(x)^SHR10(x); rotates are 32-bit circular, shifts zero-fill.
REQ-018 All additions SHALL be 32-bit with the carry out discarded.
REQ-019 On transfer with t=63: go to DONE; t SHALL NOT wrap to 0 in RUN.
REQ-020 DONE: done=1, wValid=0, busy=0 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-021 start SHALL be ignored in RUN and DONE; blockIn SHALL be sampled only on the IDLE start cycle.
REQ-022 Back-to-back transfers (wReady held high) SHALL deliver 64 words in 64 consecutive cycles.
REQ-023 IDLE: wValid=0, busy=0, done=0; wOut holds its last value and is don't-care.

Reset
REQ-024 resetn=0 SHALL immediately force IDLE, t=0, window=0, wOut=0, tOut=0, wValid=0, busy=0, done=0, including mid-RUN.
REQ-025 After reset release, no word is emitted until a new start.

Structure
REQ-026 Shared package sha256_pkg SHALL hold: the state enumeration, WORD_W=32, SCHED_LEN=64, WINDOW_LEN=16, and the s0/s1 rotate/shift amounts.
REQ-027 One sub-module, sha256_small_sigma (input x, outputs s0 and s1, purely combinational), SHALL implement REQ-017; the adder tree stays in message_schedule.

Verification
REQ-028 "abc" block (0x61626380, 14 zero words, 0x00000018), wReady=1 -> W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405, W[63]=0x12B1EDEB; done pulse one cycle after t=63.
REQ-029 All-zero block -> 64 words equal to 0x00000000, tOut runs 0..63 in order, exactly one done pulse.
REQ-030 "abc" block with wReady toggled pseudo-randomly -> same word sequence as REQ-028; wOut/tOut stable while wValid&&!wReady.
REQ-031 start pulsed at t=10 with a different blockIn -> ignored; sequence continues with the original block.
REQ-032 resetn asserted at t=30 -> all outputs 0 in the same cycle; a new start after release -> W[0] of the new block at t=0.
REQ-033 start held high continuously -> one RUN per block with one DONE/IDLE cycle between runs; the second run restarts at t=0.
